pipe_stage_skid: RTL
====================

# pipe_stage_skid

Parametrised pipeline stage register: the generic successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries one opaque WIDTH-bit payload with a valid/ready handshake instead of a bare enable/clear pair. It has an optional two-entry skid buffer so backpressure does not form a combinational path, plus a synchronous flush and saturating stall/bubble counters. Stages instantiate it with their concatenated control and data fields as the payload.

## Interface
- WIDTH, 256: payload width in bits.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- ZERO_ON_FLUSH, 1: 1 = payload registers cleared to 0 on flush/reset; 0 = only valid bits cleared.
- CNT_BITS, 32: width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all held entries; sampled at the clock edge.
- in_valid  in  1  upstream presents a payload.
- in_ready  out  1  stage accepts a payload this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  stage holds a payload for downstream.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  WIDTH  registered payload.
- occupancy  out  2  number of held entries (0..2).
- stall_cnt  out  CNT_BITS  count of cycles with out_valid=1 and out_ready=0.
- bubble_cnt  out  CNT_BITS  count of cycles with out_valid=0 and out_ready=1.

## Operation
- Transfers: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready. Payload order is strictly preserved. Nothing is duplicated or dropped except by flush or reset.
- SKID=1 states: EMPTY (occupancy 0), ONE (main register full), TWO (main and skid registers full). in_ready = (state != TWO).
  - EMPTY: accept -> ONE, main <= in_data.
  - ONE, accept and no consume -> TWO, skid <= in_data.
  - ONE, accept and consume -> ONE, main <= in_data.
  - ONE, consume only -> EMPTY.
  - TWO, consume -> ONE, main <= skid. No accept is possible in TWO.
- SKID=0: only EMPTY and ONE exist. in_ready = !out_valid || out_ready.
- out_valid = (state != EMPTY); out_data = main register.
- Flush: next state is EMPTY. A payload accepted in the flush cycle is discarded. If ZERO_ON_FLUSH=1, the main and skid registers become 0.
- Priority: rst > flush > handshake.
- Counters: each increments by 1 per qualifying cycle and saturates at all-ones without wrapping. Flush does not clear them; rst does.

## Timing
- Reset values: out_valid=0, out_data=0, occupancy=0, stall_cnt=0, bubble_cnt=0. in_ready=1 during and after reset (both SKID modes).
- Latency: a payload accepted at edge N appears on out_data with out_valid=1 after edge N; it is consumable at edge N+1.
- Throughput: 1 payload per cycle sustained while out_ready=1, in both modes.
- SKID=1: in_ready depends only on state (register output), so there is no out_ready->in_ready combinational path. in_ready falls the cycle after the second entry is captured.
- SKID=0: in_ready combinationally follows out_ready.
- Counters update on the same edge as the qualifying cycle; the new value is visible the following cycle.
- Flush asserted together with out_ready=1 and out_valid=1: the current output counts as consumed downstream. The stage is still EMPTY afterwards.
- Reset mid-operation (state TWO): the next cycle is EMPTY with all outputs at their reset values.

## Test plan
- Streaming, SKID=1: hold out_ready=1 and drive in_data=1,2,3,4 on consecutive cycles. Required: out_data is 1,2,3,4 one cycle later, in_ready stays 1, and bubble_cnt equals the idle cycles before the first beat.
- Backpressure, SKID=1: send 0xA then 0xB with out_ready=0. Required: occupancy 1 then 2, in_ready=0 after 0xB. Then raise out_ready: outputs are 0xA then 0xB, and stall_cnt equals the number of cycles with out_ready=0 while out_valid=1.
- SKID=0 pass-through: out_ready=0 with one entry held. Required: in_ready=0 in the same cycle. Raising out_ready gives in_ready=1 in the same cycle, and a simultaneous accept and consume keeps occupancy 1.
- Flush, ZERO_ON_FLUSH=1: in state TWO holding 0x5 and 0x6, assert flush together with in_valid=1, in_data=0x7. Required next cycle: out_valid=0, out_data=0, occupancy 0, and 0x7 never emitted.
- Reset vs flush vs saturation: set CNT_BITS=4 and hold out_valid=1, out_ready=0 for 20 cycles. Required: stall_cnt saturates at 15. Asserting flush leaves the counter at 15; asserting rst together with flush clears it to 0 and gives in_ready=1.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage register with optional two-entry skid buffer,
// synchronous flush and saturating stall/bubble counters.
module pipe_stage_skid #(
    parameter int WIDTH         = 256,
    parameter bit SKID          = 1'b1,
    parameter bit ZERO_ON_FLUSH = 1'b1,
    parameter int CNT_BITS      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic [1:0]          occupancy,
    output logic [CNT_BITS-1:0] stall_cnt,
    output logic [CNT_BITS-1:0] bubble_cnt
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] main_q, skid_q, main_nxt, skid_nxt;
    logic             accept, consume;

    // With SKID=1 in_ready is a pure function of registered state, breaking the
    // out_ready->in_ready path; SKID=0 never reaches TWO.
    assign in_ready  = SKID ? (state != TWO) : (!out_valid || out_ready);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state;
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst && ZERO_ON_FLUSH) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_nxt;
            skid_q <= skid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        unique case (state)
            EMPTY: if (accept) begin
                state_nxt = ONE;
                main_nxt  = in_data;
            end
            ONE: begin
                if (accept && consume) begin
                    main_nxt = in_data;
                end else if (accept) begin
                    state_nxt = TWO;
                    skid_nxt  = in_data;
                end else if (consume) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: if (consume) begin
                state_nxt = ONE;
                main_nxt  = skid_q;
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush overrides the handshake; anything accepted this cycle is lost.
        if (flush) begin
            state_nxt = EMPTY;
            if (ZERO_ON_FLUSH) begin
                main_nxt = '0;
                skid_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_BITS'(1);
            if (!out_valid && out_ready && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + CNT_BITS'(1);
        end
    end

endmodule
